// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath + memory port.
// master = sequencer side (drives strobes/selects), slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        oldpc_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [1:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  inst, br_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, oldpc_we, pc_we, pc_src,
               alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, illegal, instret
    );

    modport slave (
        output inst, br_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, oldpc_we, pc_we, pc_src,
               alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: 3-5 cycles/instruction, outputs decoded from state + IR opcode.
// Stalls in FETCH/MEM while mem_ready is low; mem_req is held until the ready cycle.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    state_t      state_q, state_d;
    logic [31:0] instret_q;
    logic [6:0]  opc;
    logic        opc_legal;

    assign opc = bus.inst[6:0];

    always_comb begin
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_LUI, OPC_JAL, OPC_JALR: opc_legal = 1'b1;
            default:                                opc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.oldpc_we     = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = 2'd0;
        bus.alu_a_sel    = 2'd0;
        bus.alu_b_sel    = 2'd0;
        bus.alu_op       = 2'd0;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = 2'd0;
        bus.retire       = 1'b0;
        bus.illegal      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.oldpc_we = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            // old PC + imm lands in ALUOut as the branch/JAL target
            S_DECODE: begin
                bus.alu_a_sel = 2'd1;
                bus.alu_b_sel = 2'd1;
                state_d       = opc_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opc)
                    OPC_OP: begin
                        bus.alu_op = 2'd1;
                        state_d    = S_WB;
                    end
                    OPC_OP_IMM: begin
                        bus.alu_b_sel = 2'd1;
                        bus.alu_op    = 2'd1;
                        state_d       = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        bus.alu_b_sel = 2'd1;
                        state_d       = S_MEM;
                    end
                    OPC_LUI: begin
                        bus.alu_a_sel = 2'd2;
                        bus.alu_b_sel = 2'd1;
                        state_d       = S_WB;
                    end
                    OPC_BRANCH: begin
                        bus.alu_op = 2'd2;
                        bus.pc_src = 2'd1;
                        bus.pc_we  = bus.br_taken;
                        bus.retire = 1'b1;
                        state_d    = S_FETCH;
                    end
                    // PC already holds PC+4, so the link write and PC update share this edge
                    OPC_JAL: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'd1;
                        bus.rf_we  = 1'b1;
                        bus.wb_sel = 2'd2;
                        bus.retire = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OPC_JALR: begin
                        bus.alu_b_sel = 2'd1;
                        bus.pc_we     = 1'b1;
                        bus.pc_src    = 2'd2;
                        bus.rf_we     = 1'b1;
                        bus.wb_sel    = 2'd2;
                        bus.retire    = 1'b1;
                        state_d       = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (opc == OPC_STORE);
                if (bus.mem_ready) begin
                    if (opc == OPC_STORE) begin
                        bus.retire = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d    = S_WB;
                    end
                end
            end
            S_WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = (opc == OPC_LOAD) ? 2'd1 : 2'd0;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  bus.illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (bus.retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.instret = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed sequencing, CPI, strobes and reset behaviour.
module tb_multicycle_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_2083;
    localparam logic [31:0] I_SW    = 32'h0011_2023;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_JAL   = 32'h0080_00ef;
    localparam logic [31:0] I_JALR  = 32'h0000_80e7;
    localparam logic [31:0] I_LUI   = 32'h1234_50b7;
    localparam logic [31:0] I_ADD   = 32'h0020_81b3;
    localparam logic [31:0] I_AUIPC = 32'h0000_0097;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts in a FETCH cycle; answers each memory burst after fw (first) / mw (second) wait cycles.
    // Snapshots the strobes of the retire cycle and returns once back in FETCH.
    task automatic run_insn(input logic [31:0] ins, input int fw, input int mw, input logic bt,
                            output int cyc, output int n_ir, output int n_rf,
                            output logic [7:0] snap);
        int  burst;
        int  waited;
        bit  done;
        burst = 0; waited = 0; done = 0;
        cyc = 0; n_ir = 0; n_rf = 0; snap = '0;
        bus.inst     = ins;
        bus.br_taken = bt;
        for (int k = 0; k < 40 && !done; k++) begin
            if (bus.mem_req) bus.mem_ready = (waited >= ((burst == 0) ? fw : mw));
            else             bus.mem_ready = 1'b1;
            #1;
            cyc++;
            if (bus.ir_we) n_ir++;
            if (bus.rf_we) n_rf++;
            if (bus.mem_req && bus.mem_ready) begin
                burst++;
                waited = 0;
            end else if (bus.mem_req) begin
                waited++;
            end
            if (bus.retire) begin
                snap = {bus.pc_we, bus.pc_src, bus.rf_we, bus.wb_sel, bus.mem_we, bus.mem_req};
                done = 1;
            end
            step();
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $error("FAIL run_insn_timeout: observed no retire expected retire within 40 cycles");
        end
    endtask

    initial begin
        int         cyc, n_ir, n_rf, bad;
        logic [7:0] snap;
        n_tests = 0;
        n_fail  = 0;
        rst_n        = 1'b0;
        bus.inst     = I_ADDI;
        bus.br_taken = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) step();
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_ir_we", {31'd0, bus.ir_we}, 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);

        // ADDI, cycle by cycle from reset release
        rst_n = 1'b1;
        #1;
        chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        chk("fetch_req_ir_pc_old", {28'd0, bus.mem_req, bus.ir_we, bus.pc_we, bus.oldpc_we}, 32'hF);
        chk("fetch_srcs", {28'd0, bus.pc_src, 1'b0, bus.mem_addr_sel}, 32'd0);
        step();
        chk("decode_sel", {24'd0, bus.alu_a_sel, bus.alu_b_sel, bus.alu_op, bus.mem_req, bus.rf_we},
            {24'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0});
        step();
        chk("exec_addi", {24'd0, bus.alu_a_sel, bus.alu_b_sel, bus.alu_op, bus.rf_we, bus.retire},
            {24'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0});
        step();
        chk("wb_addi", {28'd0, bus.rf_we, bus.retire, bus.wb_sel}, {28'd0, 1'b1, 1'b1, 2'd0});
        step();
        chk("addi_instret", bus.instret, 32'd1);

        // snap = {pc_we, pc_src[1:0], rf_we, wb_sel[1:0], mem_we, mem_req}
        run_insn(I_LW, 3, 3, 1'b0, cyc, n_ir, n_rf, snap);
        chk("lw_cycles", cyc, 11);
        chk("lw_ir_we_pulses", n_ir, 1);
        chk("lw_wb", {24'd0, snap}, {24'd0, 8'b0_00_1_01_0_0});
        run_insn(I_BEQ, 0, 0, 1'b0, cyc, n_ir, n_rf, snap);
        chk("beq_nt_cycles", cyc, 3);
        chk("beq_nt_exec", {24'd0, snap}, {24'd0, 8'b0_01_0_00_0_0});
        chk("beq_nt_rf_we", n_rf, 0);
        run_insn(I_BEQ, 0, 0, 1'b1, cyc, n_ir, n_rf, snap);
        chk("beq_t_cycles", cyc, 3);
        chk("beq_t_exec", {24'd0, snap}, {24'd0, 8'b1_01_0_00_0_0});
        run_insn(I_JAL, 0, 0, 1'b0, cyc, n_ir, n_rf, snap);
        chk("jal_cycles", cyc, 3);
        chk("jal_exec", {24'd0, snap}, {24'd0, 8'b1_01_1_10_0_0});
        run_insn(I_JALR, 0, 0, 1'b0, cyc, n_ir, n_rf, snap);
        chk("jalr_cycles", cyc, 3);
        chk("jalr_exec", {24'd0, snap}, {24'd0, 8'b1_10_1_10_0_0});
        chk("jalr_next_fetch", {31'd0, bus.mem_req}, 32'd1);
        run_insn(I_SW, 0, 2, 1'b0, cyc, n_ir, n_rf, snap);
        chk("sw_cycles", cyc, 6);
        chk("sw_mem", {24'd0, snap}, {24'd0, 8'b0_00_0_00_1_1});
        chk("sw_rf_we", n_rf, 0);
        run_insn(I_LUI, 0, 0, 1'b0, cyc, n_ir, n_rf, snap);
        chk("lui_cycles", cyc, 4);
        run_insn(I_ADD, 1, 0, 1'b0, cyc, n_ir, n_rf, snap);
        chk("add_cycles", cyc, 5);
        chk("add_wb", {24'd0, snap}, {24'd0, 8'b0_00_1_00_0_0});
        chk("instret_9", bus.instret, 32'd9);

        // counter wrap: preload all-ones in a non-retiring FETCH cycle
        dut.instret_q = 32'hFFFF_FFFF;
        run_insn(I_ADDI, 0, 0, 1'b0, cyc, n_ir, n_rf, snap);
        chk("instret_wrap", bus.instret, 32'd0);

        // async reset while a load sits in MEM with mem_req held
        bus.inst = I_LW;
        bus.mem_ready = 1'b1;
        step(); step(); step();
        bus.mem_ready = 1'b0;
        #1;
        chk("mem_hold", {30'd0, bus.mem_req, bus.mem_addr_sel}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mem_rst_outs", {26'd0, bus.mem_req, bus.mem_addr_sel, bus.retire, bus.rf_we, bus.ir_we, bus.pc_we}, 32'd0);
        chk("mem_rst_instret", bus.instret, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_fetch", {31'd0, bus.mem_req}, 32'd1);

        // unsupported opcode traps and stays trapped
        bus.inst = I_AUIPC;
        bus.mem_ready = 1'b1;
        step();
        chk("trap_decode_illegal", {31'd0, bus.illegal}, 32'd0);
        step();
        chk("trap_illegal", {31'd0, bus.illegal}, 32'd1);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.mem_req !== 1'b0 || bus.illegal !== 1'b1 || bus.retire !== 1'b0) bad++;
            step();
        end
        chk("trap_hold_100", bad, 0);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_clear", {31'd0, bus.illegal}, 32'd0);
        step();
        rst_n = 1'b1;
        bus.inst = I_ADDI;
        step();
        chk("trap_rst_fetch", {30'd0, bus.mem_req, bus.illegal}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
